io_bus_ctrl: RTL

//  Sequences every CPU MMIO access to the I/O window 0xfffffc00-0xfffffcff. Decodes the target

---
 rtl/io_bus_ctrl_pkg.sv | 22 ++
 rtl/io_bus_ctrl_if.sv | 25 ++
 rtl/io_bus_ctrl_addr_decode.sv | 24 ++
 rtl/io_bus_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// Shared constants, state encoding and counter helper for the MMIO window controller.
package io_bus_ctrl_pkg;

    localparam logic [23:0] IO_BASE_HI = 24'hfffffc;

    localparam int SLOT_TIMER  = 2;
    localparam int SLOT_SEG    = 3;
    localparam int SLOT_LED    = 6;
    localparam int SLOT_SWITCH = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// CPU-side MMIO request/response bundle; the controller takes the slave end.
interface io_bus_ctrl_if;
    import io_bus_ctrl_pkg::*;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byte_sel;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_byte_sel, cpu_wdata,
        input  cpu_stall, cpu_ack, cpu_err, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_byte_sel, cpu_wdata,
        output cpu_stall, cpu_ack, cpu_err, cpu_rdata
    );

endinterface

// File: rtl/io_bus_ctrl_addr_decode.sv
// Purpose: maps a CPU byte address onto an I/O window slot (hit, slot id, one-hot enable).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module io_addr_decode
    import io_bus_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic [31:0]          addr,
    output logic                 hit,
    output logic [3:0]           slot,
    output logic [NUM_SLOTS-1:0] onehot
);

    always_comb begin
        slot   = addr[7:4];
        hit    = (addr[31:8] == IO_BASE_HI) && (32'(addr[7:4]) < NUM_SLOTS);
        onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            onehot[i] = hit && (32'(addr[7:4]) == i);
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Purpose: sequences one CPU MMIO access at a time onto the shared peripheral bus.
// Latency: zero-wait read acks 2 cycles after acceptance, +1 per wait state; decode errors ack in 1.
// Backpressure: cpu_stall holds the pipeline until ack; per-slot wait states and per_ready stretch the access.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int                     NUM_SLOTS = 8,
    parameter logic [4*NUM_SLOTS-1:0] WAIT_CYC  = {NUM_SLOTS{4'd0}},
    parameter int                     TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    io_bus_ctrl_if.slave            cpu,
    output logic [31:0]             per_addr,
    output logic [NUM_SLOTS-1:0]    per_en,
    output logic                    per_we,
    output logic [3:0]              per_byte_sel,
    output logic [31:0]             per_wdata,
    input  logic [NUM_SLOTS*32-1:0] per_rdata,
    input  logic [NUM_SLOTS-1:0]    per_ready
);

    state_t                 state;
    logic [3:0]             slot_q;
    logic [3:0]             wait_cnt;
    logic [3:0]             to_cnt;
    logic                   ack_q;
    logic                   err_q;
    logic [31:0]            rdata_q;

    logic                   dec_hit;
    logic [3:0]             dec_slot;
    logic [NUM_SLOTS-1:0]   dec_onehot;

    logic [3:0]             sel_wait;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   done;

    io_addr_decode #(.NUM_SLOTS(NUM_SLOTS)) u_decode (
        .addr   (cpu.cpu_addr),
        .hit    (dec_hit),
        .slot   (dec_slot),
        .onehot (dec_onehot)
    );

    always_comb begin
        sel_wait  = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (32'(slot_q) == i) begin
                sel_wait  = WAIT_CYC[4*i +: 4];
                sel_ready = per_ready[i];
                sel_rdata = per_rdata[32*i +: 32];
            end
        end
    end

    assign done = (wait_cnt >= sel_wait) && sel_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            slot_q       <= '0;
            wait_cnt     <= '0;
            to_cnt       <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            per_en       <= '0;
            per_addr     <= '0;
            per_we       <= 1'b0;
            per_byte_sel <= '0;
            per_wdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu.cpu_req) begin
                        slot_q <= dec_slot;
                        if (!dec_hit) begin
                            state <= S_ERR;
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                        end else if (cpu.cpu_we && cpu.cpu_byte_sel == 4'h0) begin
                            state   <= S_RESP;
                            ack_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state        <= S_ACCESS;
                            wait_cnt     <= '0;
                            to_cnt       <= '0;
                            per_en       <= dec_onehot;
                            per_addr     <= cpu.cpu_addr;
                            per_we       <= cpu.cpu_we;
                            per_byte_sel <= cpu.cpu_byte_sel;
                            per_wdata    <= cpu.cpu_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= sat_inc(wait_cnt);
                    to_cnt   <= sat_inc(to_cnt);
                    // Completion is checked first so a late ready still beats the timeout.
                    if (done || to_cnt == 4'(TIMEOUT)) begin
                        state        <= done ? S_RESP : S_ERR;
                        ack_q        <= 1'b1;
                        err_q        <= !done;
                        rdata_q      <= (done && !per_we) ? sel_rdata : 32'h0;
                        per_en       <= '0;
                        per_addr     <= '0;
                        per_we       <= 1'b0;
                        per_byte_sel <= '0;
                        per_wdata    <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_err   = err_q;
    assign cpu.cpu_rdata = rdata_q;
    // Gated by reset so the stall drops immediately when reset is asserted.
    assign cpu.cpu_stall = rst & cpu.cpu_req & ~ack_q;

endmodule
